// File: rtl/mapper_pkg.sv
// Shared definitions for the bank mapper.
// Holds the default register window base, the layout of one mapper entry
// {mapped, readonly, page[6:0]}, the write-FSM state type and a helper that
// formats an entry as a host-visible byte.
package mapper_pkg;

    localparam logic [15:0] WIN_BASE_DEFAULT = 16'h4000;

    localparam int N_ENTRIES   = 16;
    localparam int IDX_W       = 4;
    localparam int PAGE_W      = 7;
    localparam int ENTRY_W     = PAGE_W + 2;
    localparam int ENT_MAP_BIT = 8;
    localparam int ENT_RO_BIT  = 7;
    localparam int ENT_PAGE_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } wr_state_t;

    // Even byte: {mapped, readonly, 6'b0}; odd byte: {1'b0, page}.
    // Reserved bits always read as zero.
    function automatic logic [7:0] entry_byte(input logic [ENTRY_W-1:0] ent,
                                              input logic              odd);
        logic [7:0] b;
        if (odd) begin
            b = {1'b0, ent[ENT_PAGE_LO +: PAGE_W]};
        end else begin
            b = {ent[ENT_MAP_BIT], ent[ENT_RO_BIT], 6'b00_0000};
        end
        return b;
    endfunction

endpackage

// File: rtl/bank_mapper_if.sv
// Host/memory-side bus of the bank mapper.
// master: host + memory interface (drives address/data/strobes/bank_sel).
// slave : the mapper (drives lookup results, readback and debug state).
// Handshake: a host write is framed by the active-low strobe `we`; the mapper
// arms on the synchronized falling edge while the window is hit and commits
// the last sampled data byte on the synchronized rising edge. There is no
// ready/back-pressure; the host must hold `we` low long enough to be seen.
interface bank_mapper_if;
    import mapper_pkg::*;

    logic [15:0] i_address_bus;
    logic [7:0]  i_data_bus;
    logic        memen;
    logic        we;
    logic        dbin;
    logic        map_sel;
    logic        map_mode;
    logic [3:0]  bank_sel;

    logic        bank_mapped;
    logic        bank_readonly;
    logic [6:0]  bank_address;
    logic [7:0]  o_data_bus;
    logic        o_rd_en;
    wr_state_t   o_dbg_state;

    modport master (
        output i_address_bus, i_data_bus, memen, we, dbin, map_sel, map_mode, bank_sel,
        input  bank_mapped, bank_readonly, bank_address, o_data_bus, o_rd_en, o_dbg_state
    );

    modport slave (
        input  i_address_bus, i_data_bus, memen, we, dbin, map_sel, map_mode, bank_sel,
        output bank_mapped, bank_readonly, bank_address, o_data_bus, o_rd_en, o_dbg_state
    );
endinterface

// File: rtl/sync_edge.sv
// Multi-stage synchronizer with edge pulses for an asynchronous level.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-low reset; chain resets to 1 (idle-high input)
//   i_async - asynchronous input level
//   o_sync  - synchronized level
//   o_rise  - one-cycle pulse on a synchronized 0->1 transition
//   o_fall  - one-cycle pulse on a synchronized 1->0 transition
// STAGES must be at least 2.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_chain <= '1;
            r_prev  <= 1'b1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = ~r_prev &  o_sync;
    assign o_fall =  r_prev & ~o_sync;

endmodule

// File: rtl/bank_mapper.sv
// Bank mapper: 16-entry {mapped, readonly, page} register file behind a
// 32-byte host window, plus a registered lookup indexed by bank_sel.
// Ports:
//   clk   - system clock
//   reset - synchronous active-low reset
//   bus   - bank_mapper_if.slave: host address/data/strobes, map_sel,
//           map_mode, bank_sel in; lookup results, readback byte/enable
//           and write-FSM debug state out
module bank_mapper
    import mapper_pkg::*;
#(
    parameter logic [15:0] WIN_BASE    = WIN_BASE_DEFAULT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    bank_mapper_if.slave bus
);

    wr_state_t          r_state;
    wr_state_t          w_state_nxt;
    logic               w_capture;
    logic               w_commit;

    logic [IDX_W-1:0]   r_idx;
    logic               r_odd;
    logic [7:0]         r_data;
    logic [ENTRY_W-1:0] r_entry [N_ENTRIES];

    logic               r_bank_mapped;
    logic               r_bank_readonly;
    logic [6:0]         r_bank_address;

    logic               w_hit;
    logic               w_we_rise;
    logic               w_we_fall;
    logic               w_we_sync;
    logic [ENTRY_W-1:0] w_rd_entry;
    logic [ENTRY_W-1:0] w_lk_entry;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_we_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.we),
        .o_sync  (w_we_sync),
        .o_rise  (w_we_rise),
        .o_fall  (w_we_fall)
    );

    assign w_hit = bus.map_sel && !bus.memen &&
                   (bus.i_address_bus[15:5] == WIN_BASE[15:5]);

    // Write FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write FSM: next state and strobes. The window hit only matters at the
    // arming edge; memen may drop during ARMED without aborting the write.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_we_fall && w_hit) begin
                    w_state_nxt = ST_ARMED;
                    w_capture   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (w_we_rise) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Captured target and data sample. Data keeps tracking the bus while
    // ARMED so the commit uses the value present just before `we` rose.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx  <= '0;
            r_odd  <= 1'b0;
            r_data <= '0;
        end else begin
            if (w_capture) begin
                r_idx <= bus.i_address_bus[4:1];
                r_odd <= bus.i_address_bus[0];
            end
            if (r_state == ST_ARMED) begin
                r_data <= bus.i_data_bus;
            end
        end
    end

    // Entry register file; reset value maps each entry to its own page.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_entry[i] <= {1'b0, 1'b0, PAGE_W'(i)};
            end
        end else if (w_commit) begin
            if (r_odd) begin
                r_entry[r_idx][ENT_PAGE_LO +: PAGE_W] <= r_data[PAGE_W-1:0];
            end else begin
                r_entry[r_idx][ENT_MAP_BIT] <= r_data[7];
                r_entry[r_idx][ENT_RO_BIT]  <= r_data[6];
            end
        end
    end

    // Registered lookup; reads the array directly, so a commit is visible
    // one edge after the array itself updates.
    assign w_lk_entry = r_entry[bus.bank_sel];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bank_mapped   <= 1'b0;
            r_bank_readonly <= 1'b0;
            r_bank_address  <= '0;
        end else if (!bus.map_mode) begin
            r_bank_mapped   <= 1'b1;
            r_bank_readonly <= 1'b0;
            r_bank_address  <= {3'b000, bus.bank_sel};
        end else begin
            r_bank_mapped   <= w_lk_entry[ENT_MAP_BIT];
            r_bank_readonly <= w_lk_entry[ENT_RO_BIT];
            r_bank_address  <= w_lk_entry[ENT_PAGE_LO +: PAGE_W];
        end
    end

    // Combinational readback
    assign w_rd_entry     = r_entry[bus.i_address_bus[4:1]];
    assign bus.o_rd_en    = w_hit && bus.dbin;
    assign bus.o_data_bus = bus.o_rd_en ? entry_byte(w_rd_entry, bus.i_address_bus[0]) : 8'h00;

    assign bus.bank_mapped   = r_bank_mapped;
    assign bus.bank_readonly = r_bank_readonly;
    assign bus.bank_address  = r_bank_address;
    assign bus.o_dbg_state   = r_state;

endmodule

// File: tb/tb_bank_mapper.sv
module tb_bank_mapper;
    import mapper_pkg::*;

    localparam logic [10:0] WIN_TAG = 11'h200; // 16'h4000 >> 5

    logic clk;
    logic reset;
    bank_mapper_if bus();

    bank_mapper #(
        .WIN_BASE    (16'h4000),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    logic [8:0] mdl [16];       // {mapped, readonly, page}
    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = {2'b00, 7'(i)};
    endtask

    task automatic model_write(input logic [15:0] addr, input logic [7:0] data);
        if (!addr[0]) mdl[addr[4:1]][8:7] = data[7:6];
        else          mdl[addr[4:1]][6:0] = data[6:0];
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        bus.i_address_bus = 16'h0000;
        bus.i_data_bus    = 8'h00;
        bus.memen         = 1'b1;
        bus.we            = 1'b1;
        bus.dbin          = 1'b0;
        bus.map_sel       = 1'b0;
    endtask

    task automatic host_write(input logic [15:0] addr, input logic [7:0] data,
                              input logic msel, input logic early_release);
        @(negedge clk);
        bus.i_address_bus = addr;
        bus.i_data_bus    = data;
        bus.map_sel       = msel;
        bus.memen         = 1'b0;
        bus.dbin          = 1'b0;
        @(negedge clk);
        bus.we = 1'b0;
        repeat (5) @(negedge clk);
        if (early_release) bus.memen = 1'b1;
        @(negedge clk);
        bus.we = 1'b1;
        repeat (6) @(negedge clk);
        bus_idle();
        if (msel && addr[15:5] == WIN_TAG) model_write(addr, data);
    endtask

    task automatic host_read(input logic [15:0] addr, input logic msel, output logic [8:0] got);
        @(negedge clk);
        bus.i_address_bus = addr;
        bus.map_sel       = msel;
        bus.memen         = 1'b0;
        bus.dbin          = 1'b1;
        #1;
        got = {bus.o_rd_en, bus.o_data_bus};
        @(negedge clk);
        bus_idle();
    endtask

    task automatic set_lookup(input logic mode, input logic [3:0] sel);
        @(negedge clk);
        bus.map_mode = mode;
        bus.bank_sel = sel;
        exp_q.push_back(mode ? mdl[sel] : {2'b10, 3'b000, sel});
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [8:0] got, exp;
        reset = 1'b0;
        bus_idle();
        bus.map_mode = 1'b0;
        bus.bank_sel = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
        if (got !== 9'h000) begin
            errors++; $display("FAIL reset_lookup got %h required %h", got, 9'h000);
        end
        checks++;
        if (bus.o_dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL reset_state got %0d required %0d", bus.o_dbg_state, ST_IDLE);
        end
        reset = 1'b1;
        model_reset();
        // odd byte of entry 5 holds its reset page
        exp_q.push_back({1'b1, 8'h05});
        host_read(16'h400B, 1'b1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_page_readback got %h required %h", got, exp);
        end
        exp_q.push_back({1'b1, 8'h00});
        host_read(16'h400A, 1'b1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_flags_readback got %h required %h", got, exp);
        end
    endtask

    task automatic test_passthrough();
        logic [8:0] got, exp;
        set_lookup(1'b0, 4'hA);
        got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || exp !== {2'b10, 7'h0A}) begin
            errors++; $display("FAIL passthrough_A got %h required %h", got, {2'b10, 7'h0A});
        end
        for (int i = 0; i < 4; i++) begin
            set_lookup(1'b0, 4'($urandom_range(0, 15)));
            got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL passthrough_rand got %h required %h", got, exp);
            end
        end
        // mapped lookup of untouched entry A shows its reset contents
        set_lookup(1'b1, 4'hA);
        got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL mapped_reset_entry got %h required %h", got, exp);
        end
    endtask

    task automatic test_write_lookup();
        logic [8:0] got, exp;
        bus.map_mode = 1'b0;          // writes accepted in pass-through mode
        host_write(16'h4006, 8'h80, 1'b1, 1'b0);
        host_write(16'h4007, 8'h25, 1'b1, 1'b0);
        set_lookup(1'b1, 4'h3);
        got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || exp !== {2'b10, 7'h25}) begin
            errors++; $display("FAIL write_lookup_e3 got %h required %h", got, {2'b10, 7'h25});
        end
    endtask

    task automatic test_readback();
        logic [8:0] got, exp;
        host_write(16'h4006, 8'hC0, 1'b1, 1'b0);
        exp_q.push_back({1'b1, 8'hC0});
        host_read(16'h4006, 1'b1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL readback_even got %h required %h", got, exp);
        end
        exp_q.push_back({1'b1, 8'h25});
        host_read(16'h4007, 1'b1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL readback_odd got %h required %h", got, exp);
        end
    endtask

    task automatic test_no_hit();
        logic [8:0] got, exp;
        host_write(16'h4006, 8'h3F, 1'b0, 1'b0);
        host_write(16'h4020, 8'h3F, 1'b1, 1'b0);
        exp_q.push_back(9'h000);
        host_read(16'h4006, 1'b0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL nohit_mapsel0_read got %h required %h", got, exp);
        end
        exp_q.push_back(9'h000);
        host_read(16'h4020, 1'b1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL nohit_outside_read got %h required %h", got, exp);
        end
        exp_q.push_back({1'b1, mdl[3][8:7], 6'b0});
        host_read(16'h4006, 1'b1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || exp !== 9'h1C0) begin
            errors++; $display("FAIL nohit_entry3_even got %h required %h", got, 9'h1C0);
        end
        exp_q.push_back({1'b1, 1'b0, mdl[3][6:0]});
        host_read(16'h4007, 1'b1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL nohit_entry3_odd got %h required %h", got, exp);
        end
    endtask

    task automatic test_commit_timing();
        logic [8:0] got, exp;
        int budget;
        set_lookup(1'b1, 4'h3);
        got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL timing_pre got %h required %h", got, exp);
        end
        @(negedge clk);
        bus.i_address_bus = 16'h4007;
        bus.i_data_bus    = 8'h11;
        bus.map_sel       = 1'b1;
        bus.memen         = 1'b0;
        @(negedge clk);
        bus.we = 1'b0;
        repeat (5) @(negedge clk);
        bus.we = 1'b1;
        exp_q.push_back(mdl[3]);                 // still old after first edge
        model_write(16'h4007, 8'h11);
        exp_q.push_back(mdl[3]);                 // new at second edge
        budget = 0;
        while (bus.o_dbg_state !== ST_COMMIT && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (bus.o_dbg_state !== ST_COMMIT) begin
            errors++; $display("FAIL timing_commit_seen got %0d required %0d", bus.o_dbg_state, ST_COMMIT);
        end
        @(negedge clk);
        got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL timing_edge1 got %h required %h", got, exp);
        end
        @(negedge clk);
        got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got[6:0] !== 7'h11) begin
            errors++; $display("FAIL timing_edge2 got %h required %h", got, exp);
        end
        bus_idle();
    endtask

    task automatic test_reset_armed();
        logic [8:0] got, exp;
        int budget;
        @(negedge clk);
        bus.i_address_bus = 16'h401F;
        bus.i_data_bus    = 8'h7F;
        bus.map_sel       = 1'b1;
        bus.memen         = 1'b0;
        @(negedge clk);
        bus.we = 1'b0;
        budget = 0;
        while (bus.o_dbg_state !== ST_ARMED && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (bus.o_dbg_state !== ST_ARMED) begin
            errors++; $display("FAIL armed_reached got %0d required %0d", bus.o_dbg_state, ST_ARMED);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bus.we = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (6) @(negedge clk);
        checks++;
        if (bus.o_dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL reset_armed_state got %0d required %0d", bus.o_dbg_state, ST_IDLE);
        end
        bus_idle();
        exp_q.push_back({1'b1, 8'h0F});
        host_read(16'h401F, 1'b1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_armed_e15 got %h required %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  got, exp;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [3:0]  idx;
        for (int n = 0; n < 8; n++) begin
            idx  = 4'($urandom_range(0, 15));
            addr = {11'h200, idx, 1'($urandom_range(0, 1))};
            data = 8'($urandom_range(0, 255));
            host_write(addr, data, 1'b1, 1'($urandom_range(0, 1)));
            exp_q.push_back({1'b1, (addr[0] ? {1'b0, mdl[idx][6:0]} : {mdl[idx][8:7], 6'b0})});
            host_read(addr, 1'b1, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL b2b_readback addr %h got %h required %h", addr, got, exp);
            end
            set_lookup(1'b1, idx);
            got = {bus.bank_mapped, bus.bank_readonly, bus.bank_address};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL b2b_lookup idx %0d got %h required %h", idx, got, exp);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_passthrough();
        test_write_lookup();
        test_readback();
        test_no_hit();
        test_commit_timing();
        test_reset_armed();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
